fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 100 ++++++++++
 tb/tb_fetch_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one outstanding bus request at a time,
// buffers the returned word for decode and follows redirects from later stages.
module fetch_ctrl #(
    parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] req_addr;
    logic [63:0] tgt;

    assign tgt       = {redirect_pc[63:2], 2'b00};
    assign ireq_addr = req_addr;

    always_ff @(posedge clk) begin
        state_t nxt;
        nxt = state;
        if (!reset) begin
            nxt         = IDLE;
            pc          <= PC_RESET;
            req_addr    <= PC_RESET;
            inst        <= '0;
            inst_pc     <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    nxt = REQ;
                    if (redirect_valid) begin
                        pc       <= tgt;
                        req_addr <= tgt;
                    end else begin
                        req_addr <= pc;
                    end
                end
                REQ: begin
                    if (redirect_valid && iresp_data_ok) begin
                        // Response and redirect coincide: bus is free, restart at target now
                        pc       <= tgt;
                        req_addr <= tgt;
                    end else if (redirect_valid) begin
                        pc  <= tgt;
                        nxt = DRAIN;
                    end else if (iresp_data_ok) begin
                        inst    <= iresp_data;
                        inst_pc <= req_addr;
                        pc      <= req_addr + 64'd4;
                        nxt     = HOLD;
                    end
                end
                DRAIN: begin
                    // Stale request still outstanding; its data is discarded
                    if (iresp_data_ok) begin
                        nxt = REQ;
                        if (redirect_valid) begin
                            pc       <= tgt;
                            req_addr <= tgt;
                        end else begin
                            req_addr <= pc;
                        end
                    end else if (redirect_valid) begin
                        pc <= tgt;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc       <= tgt;
                        req_addr <= tgt;
                        nxt      = REQ;
                    end else if (inst_ready) begin
                        fetch_count <= fetch_count + 64'd1;
                        req_addr    <= pc;
                        nxt         = REQ;
                    end
                end
                default: nxt = IDLE;
            endcase
        end
        state      <= nxt;
        ireq_valid <= (nxt == REQ) || (nxt == DRAIN);
        inst_valid <= (nxt == HOLD);
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, normal fetch, redirects in each state,
// address wrap and reset mid-request.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] fetch_count;

    int passed = 0;
    int total  = 0;

    fetch_ctrl dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0; inst_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        step(); step();
        total++; if (ireq_valid !== 1'b0) $display("FAIL reset_ireq_valid got %0b want 0", ireq_valid); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %0b want 0", inst_valid); else passed++;
        total++; if (ireq_addr !== 64'h8000_0000) $display("FAIL reset_addr got %h want 80000000", ireq_addr); else passed++;
        total++; if (fetch_count !== 64'd0) $display("FAIL reset_count got %0d want 0", fetch_count); else passed++;
    endtask

    task automatic test_basic_fetch();
        reset = 1'b1;
        step();
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000)
            $display("FAIL first_req got v=%0b a=%h want v=1 a=80000000", ireq_valid, ireq_addr); else passed++;
        step();
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000 || inst_valid !== 1'b0)
            $display("FAIL req_wait got v=%0b a=%h iv=%0b", ireq_valid, ireq_addr, inst_valid); else passed++;
        iresp_data_ok = 1'b1; iresp_data = 32'h0000_0013; inst_ready = 1'b1;
        step();
        iresp_data_ok = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 64'h8000_0000 || ireq_valid !== 1'b0)
            $display("FAIL hold_basic got iv=%0b inst=%h pc=%h rv=%0b", inst_valid, inst, inst_pc, ireq_valid); else passed++;
        step();
        inst_ready = 1'b0;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004)
            $display("FAIL next_req got v=%0b a=%h want 80000004", ireq_valid, ireq_addr); else passed++;
        total++; if (fetch_count !== 64'd1) $display("FAIL count_basic got %0d want 1", fetch_count); else passed++;
    endtask

    task automatic test_redirect_drain();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004)
            $display("FAIL drain_hold1 got v=%0b a=%h want 80000004", ireq_valid, ireq_addr); else passed++;
        step();
        total++; if (ireq_addr !== 64'h8000_0004) $display("FAIL drain_hold2 got %h want 80000004", ireq_addr); else passed++;
        iresp_data_ok = 1'b1; iresp_data = 32'hBAD0_BAD0;
        step();
        iresp_data_ok = 1'b0;
        total++; if (inst_valid !== 1'b0) $display("FAIL drain_discard got iv=%0b want 0", inst_valid); else passed++;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100)
            $display("FAIL drain_target got v=%0b a=%h want 80000100", ireq_valid, ireq_addr); else passed++;
    endtask

    task automatic test_redirect_with_data();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; iresp_data_ok = 1'b1; iresp_data = 32'h1111_1111;
        step();
        redirect_valid = 1'b0; iresp_data_ok = 1'b0;
        total++; if (inst_valid !== 1'b0) $display("FAIL coinc_discard got iv=%0b want 0", inst_valid); else passed++;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0200)
            $display("FAIL coinc_target got v=%0b a=%h want 80000200", ireq_valid, ireq_addr); else passed++;
    endtask

    task automatic test_hold_stall();
        iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF; inst_ready = 1'b0;
        step();
        iresp_data_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (inst_valid !== 1'b1 || inst !== 32'hDEAD_BEEF || inst_pc !== 64'h8000_0200 || ireq_valid !== 1'b0)
                $display("FAIL hold_stable%0d got iv=%0b inst=%h pc=%h", i, inst_valid, inst, inst_pc); else passed++;
            if (i < 4) step();
        end
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; inst_ready = 1'b1;
        step();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        total++; if (inst_valid !== 1'b0 || fetch_count !== 64'd1)
            $display("FAIL hold_drop got iv=%0b cnt=%0d want 0 1", inst_valid, fetch_count); else passed++;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0300)
            $display("FAIL hold_target got v=%0b a=%h want 80000300", ireq_valid, ireq_addr); else passed++;
    endtask

    task automatic test_double_redirect();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
        step();
        redirect_pc = 64'h8000_0500;
        step();
        redirect_valid = 1'b0;
        total++; if (ireq_addr !== 64'h8000_0300) $display("FAIL dbl_hold got %h want 80000300", ireq_addr); else passed++;
        iresp_data_ok = 1'b1;
        step();
        iresp_data_ok = 1'b0;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0500 || inst_valid !== 1'b0)
            $display("FAIL dbl_target got v=%0b a=%h iv=%0b want 80000500", ireq_valid, ireq_addr, inst_valid); else passed++;
        // redirect arriving on the draining response's cycle, with low bits set
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0600;
        step();
        redirect_pc = 64'h8000_0703; iresp_data_ok = 1'b1;
        step();
        redirect_valid = 1'b0; iresp_data_ok = 1'b0;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0700)
            $display("FAIL drain_late_redir got v=%0b a=%h want 80000700", ireq_valid, ireq_addr); else passed++;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF; iresp_data_ok = 1'b1;
        step();
        redirect_valid = 1'b0;
        total++; if (ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_align got %h", ireq_addr); else passed++;
        iresp_data_ok = 1'b1; iresp_data = 32'hCAFE_0001;
        step();
        // response while holding must not disturb the buffer
        iresp_data = 32'h5555_5555;
        step();
        iresp_data_ok = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst !== 32'hCAFE_0001 || inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL hold_ignore_ok got iv=%0b inst=%h pc=%h", inst_valid, inst, inst_pc); else passed++;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'd0 || fetch_count !== 64'd2)
            $display("FAIL wrap_pc got v=%0b a=%h cnt=%0d want 0 2", ireq_valid, ireq_addr, fetch_count); else passed++;
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        step();
        reset = 1'b1; iresp_data_ok = 1'b1; iresp_data = 32'h7777_7777;
        total++; if (ireq_valid !== 1'b0 || ireq_addr !== 64'h8000_0000 || fetch_count !== 64'd0)
            $display("FAIL mid_reset got v=%0b a=%h cnt=%0d", ireq_valid, ireq_addr, fetch_count); else passed++;
        step();
        iresp_data_ok = 1'b0;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0000 || inst_valid !== 1'b0 || fetch_count !== 64'd0)
            $display("FAIL mid_reset_stray got v=%0b a=%h iv=%0b cnt=%0d", ireq_valid, ireq_addr, inst_valid, fetch_count); else passed++;
        step();
        total++; if (inst_valid !== 1'b0 || ireq_addr !== 64'h8000_0000)
            $display("FAIL mid_reset_quiet got iv=%0b a=%h", inst_valid, ireq_addr); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_redirect_drain();
        test_redirect_with_data();
        test_hold_stall();
        test_double_redirect();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
